// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared TCDM widths, error response word and request/response
// typedefs for the L2 bank round-robin arbiter.
package l2_arb_pkg;

  localparam int TCDM_ADDR_W = 32;
  localparam int TCDM_DATA_W = 32;
  localparam int TCDM_BE_W   = 4;

  // Read data returned for an access that fails the bank address check.
  localparam logic [TCDM_DATA_W-1:0] ERR_RDATA = 32'hBADA_CCE5;

  typedef struct packed {
    logic [TCDM_ADDR_W-1:0] add;
    logic                   wen;    // 1 = read, 0 = write
    logic [TCDM_DATA_W-1:0] wdata;
    logic [TCDM_BE_W-1:0]   be;
  } tcdm_req_t;

  typedef struct packed {
    logic [TCDM_DATA_W-1:0] r_rdata;
    logic                   r_opc;
  } tcdm_resp_t;

  // Width of a master index / priority pointer; never below one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_rr_pick.sv
// l2_rr_pick: combinational round-robin picker. Scans the request vector
// starting at the priority pointer, ascending with wrap-around, and reports
// the first requester as a one-hot grant, a binary index and a valid flag.
module l2_rr_pick #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [N_MASTERS-1:0] o_gnt,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_valid
);

  logic [IDX_W-1:0] w_j;

  // Rotating priority scan; the first hit from the pointer onwards wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int off = 0; off < N_MASTERS; off++) begin
      w_j = IDX_W'((int'(i_ptr) + off) % N_MASTERS);
      if (!o_valid && i_req[w_j]) begin
        o_valid    = 1'b1;
        o_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// l2_bank_rr_arbiter: shares one single-ported L2 SRAM bank between
// N_MASTERS TCDM requesters with a registered round-robin pointer, drives
// the bank in the grant cycle and routes the 1-cycle read data back.
// Optional build macro: L2_ARB_ADDR_CHECK_EN (bank address range check).
//
// Handshake: a master holds req_i (payload may change) until it sees gnt_o
// in the same cycle; exactly one cycle after every grant the winner sees
// r_valid_o with r_rdata_o/r_opc_o. There is no response back-pressure.
module l2_bank_rr_arbiter
  import l2_arb_pkg::*;
#(
  parameter int          N_MASTERS      = 4,
  parameter int          ADDR_MEM_WIDTH = 12,
  parameter logic [31:0] BANK_BASE      = 32'h1C00_0000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_MASTERS-1:0]            req_i,
  input  logic [N_MASTERS*TCDM_ADDR_W-1:0] add_i,
  input  logic [N_MASTERS-1:0]            wen_i,
  input  logic [N_MASTERS*TCDM_DATA_W-1:0] wdata_i,
  input  logic [N_MASTERS*TCDM_BE_W-1:0]  be_i,
  output logic [N_MASTERS-1:0]            gnt_o,
  output logic [N_MASTERS-1:0]            r_valid_o,
  output logic [N_MASTERS*TCDM_DATA_W-1:0] r_rdata_o,
  output logic [N_MASTERS-1:0]            r_opc_o,
  output logic                            mem_csn_o,
  output logic [ADDR_MEM_WIDTH-1:0]       mem_add_o,
  output logic                            mem_wen_o,
  output logic [TCDM_DATA_W-1:0]          mem_wdata_o,
  output logic [TCDM_BE_W-1:0]            mem_be_o,
  input  logic [TCDM_DATA_W-1:0]          mem_rdata_i
);

  localparam int RR_W = ptr_width(N_MASTERS);

  // Registered state
  logic [RR_W-1:0] r_rr;
  logic            r_resp_v;
  logic [RR_W-1:0] r_resp_idx;
  logic            r_resp_wr;
  logic            r_resp_err;

  // Combinational arbitration signals
  tcdm_req_t              w_req [N_MASTERS];
  tcdm_req_t              w_win;
  tcdm_resp_t             w_resp;
  logic [N_MASTERS-1:0]   w_gnt;
  logic [RR_W-1:0]        w_idx;
  logic                   w_found;
  logic                   w_grant;
  logic                   w_err;
  logic                   w_access;
  logic                   w_unused;

  // Split the flat per-master buses into request structs.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      w_req[i].add   = add_i[i*TCDM_ADDR_W +: TCDM_ADDR_W];
      w_req[i].wen   = wen_i[i];
      w_req[i].wdata = wdata_i[i*TCDM_DATA_W +: TCDM_DATA_W];
      w_req[i].be    = be_i[i*TCDM_BE_W +: TCDM_BE_W];
    end
  end

  l2_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (RR_W)
  ) u_pick (
    .i_req   (req_i),
    .i_ptr   (r_rr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_found)
  );

  assign w_win   = w_req[w_idx];
  // No grant is issued while reset is asserted.
  assign w_grant = w_found & ~rst_i;

`ifdef L2_ARB_ADDR_CHECK_EN
  localparam int HI_LSB = ADDR_MEM_WIDTH + 2;
  // Winner's upper address bits must select this bank.
  assign w_err = w_grant && (w_win.add[31:HI_LSB] != BANK_BASE[31:HI_LSB]);
`else
  assign w_err = 1'b0;
`endif

  // Only the word-address slice is used by the bank; the rest is dropped.
  assign w_unused = ^{add_i, BANK_BASE};

  assign w_access = w_grant & ~w_err;
  assign gnt_o    = w_grant ? w_gnt : '0;

  // Bank drive: winner's payload when accessing, all zero when deselected.
  always_comb begin
    mem_csn_o   = 1'b1;
    mem_add_o   = '0;
    mem_wen_o   = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (w_access) begin
      mem_csn_o   = 1'b0;
      mem_add_o   = w_win.add[ADDR_MEM_WIDTH+1:2];
      mem_wen_o   = w_win.wen;
      mem_wdata_o = w_win.wdata;
      mem_be_o    = w_win.be;
    end
  end

  // Pointer advance past the winner and capture of the pending response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_resp_v   <= 1'b0;
      r_resp_idx <= '0;
      r_resp_wr  <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr <= (w_idx == RR_W'(N_MASTERS-1)) ? '0 : w_idx + 1'b1;
      end
      r_resp_v   <= w_grant;
      r_resp_idx <= w_idx;
      r_resp_wr  <= ~w_win.wen;
      r_resp_err <= w_err;
    end
  end

  // Response word for the pending access: error pattern, zero for writes,
  // otherwise the bank read data arriving this cycle.
  always_comb begin
    w_resp.r_opc   = r_resp_err;
    w_resp.r_rdata = r_resp_err ? ERR_RDATA :
                     (r_resp_wr ? '0 : mem_rdata_i);
  end

  // Route the response to the granted lane only.
  always_comb begin
    r_valid_o = '0;
    r_rdata_o = '0;
    r_opc_o   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_resp_v && !rst_i && (r_resp_idx == RR_W'(i))) begin
        r_valid_o[i]                             = 1'b1;
        r_rdata_o[i*TCDM_DATA_W +: TCDM_DATA_W]  = w_resp.r_rdata;
        r_opc_o[i]                               = w_resp.r_opc;
      end
    end
  end

endmodule

// File: doc/l2_bank_rr_arbiter.md
Name: l2_bank_rr_arbiter

Overview:
Shares one single-ported L2 SRAM bank between N TCDM-protocol requesters, such as FC data, FC instruction, uDMA TX/RX, debug and HWPE ports. It arbitrates round-robin with a registered pointer and drives the bank's chip-select, address, write-enable, data and byte-enable. It routes the 1-cycle-latency read data back to the winner. It sits between the SoC interconnect's per-bank output and the bank macro.

Parameters:
N_MASTERS, 4, number of requesters (≥1)
ADDR_MEM_WIDTH, 12, bank word-address width
BANK_BASE, 32'h1C00_0000, bank byte base address; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_i  in  N_MASTERS  request per master
add_i  in  N_MASTERS*32  byte address, master i at [i*32+:32]
wen_i  in  N_MASTERS  1=read, 0=write
wdata_i  in  N_MASTERS*32  write data
be_i  in  N_MASTERS*4  byte enables
gnt_o  out  N_MASTERS  grant, one-hot or zero
r_valid_o  out  N_MASTERS  response valid
r_rdata_o  out  N_MASTERS*32  response data
r_opc_o  out  N_MASTERS  response error flag
mem_csn_o  out  1  bank chip select, active-low
mem_add_o  out  ADDR_MEM_WIDTH  word address
mem_wen_o  out  1  1=read, 0=write
mem_wdata_o  out  32  write data
mem_be_o  out  4  byte enables
mem_rdata_i  in  32  read data, valid 1 cycle after access

Behaviour:
- Registered state:
  - rr_q: priority pointer, $clog2(N_MASTERS) bits, minimum 1.
  - resp_v_q: response-pending flag.
  - resp_idx_q: index of the granted master.
  - resp_wr_q: granted access was a write.
  - resp_err_q: granted access was in error.
- Reset values: rr_q=0; resp_v_q=0; resp_idx_q=0; resp_wr_q=0; resp_err_q=0.
- Outputs during reset: gnt_o=0, r_valid_o=0, r_rdata_o=0, r_opc_o=0, mem_csn_o=1.
- Grant is combinational, same cycle as req:
  - Search req_i starting at index rr_q, ascending, wrapping at N_MASTERS-1→0.
  - The first set bit k wins and gnt_o[k]=1.
  - No request: gnt_o=0, mem_csn_o=1.
- Memory drive in the grant cycle:
  - mem_csn_o=0.
  - mem_add_o=add_i[k][ADDR_MEM_WIDTH+1:2].
  - mem_wen_o, mem_wdata_o, mem_be_o taken from master k.
  - When mem_csn_o=1, the other memory outputs are 0.
- Pointer update: on a grant to k, rr_q <= (k==N_MASTERS-1) ? 0 : k+1. With no grant, rr_q holds. Every requester is therefore granted within N_MASTERS grant cycles.
- Response, exactly 1 cycle after the grant:
  - r_valid_o[resp_idx_q]=1.
  - r_opc_o[resp_idx_q]=resp_err_q.
  - Read: r_rdata_o[resp_idx_q]=mem_rdata_i.
  - Write: r_rdata_o[resp_idx_q]=0.
  - All non-selected r_rdata/r_opc lanes are 0.
  - Writes also return r_valid.
- Throughput: one grant per cycle, fully pipelined. A grant in cycle t and a response for the grant of t-1 coexist, including for the same master.
- Back-to-back requests from a single master are granted every cycle when there is no competition.
- Requests are not sticky: a master drops req only after gnt. Request payload changes while req is high and not yet granted are legal and are sampled at grant.
- Reset asserted mid-operation: a pending response is discarded with no r_valid, and rr_q returns to 0.
- N_MASTERS=1: rr_q is constant 0 and the grant equals req_i.
- Without the optional feature, resp_err_q is always 0.

Optional Feature:
Macro L2_ARB_ADDR_CHECK_EN.
- Defined:
  - An address is in error when add_i[k][31:ADDR_MEM_WIDTH+2] ≠ BANK_BASE[31:ADDR_MEM_WIDTH+2].
  - An erroring request is still granted and the pointer still advances.
  - mem_csn_o stays 1, so no bank access occurs.
  - Next cycle: r_valid=1, r_opc=1, r_rdata=32'hBADA_CCE5.
- Undefined: upper address bits are ignored, no check logic exists, and r_opc is always 0.

Decomposition:
- Package l2_arb_pkg holds:
  - TCDM_ADDR_W=32, TCDM_DATA_W=32, TCDM_BE_W=4.
  - ERR_RDATA=32'hBADA_CCE5.
  - Typedef tcdm_req_t {add, wen, wdata, be}.
  - Typedef tcdm_resp_t {r_rdata, r_opc}.
- Sub-module l2_rr_pick (combinational): inputs req vector and pointer; outputs one-hot grant and the binary winner index plus a valid flag.
- The top module holds all registers and the muxing.

Test Plan:
- Reset then idle: rst_i=1 for 3 cycles, then all req=0 → gnt_o=0, mem_csn_o=1, r_valid_o=0, rr_q=0.
- Single read: master 2 reads add=32'h1C00_0010, memory returns 32'hCAFE_F00D → gnt_o=4'b0100 in cycle t with mem_add_o=12'h004, mem_wen_o=1; at t+1 r_valid_o=4'b0100, lane 2 rdata=32'hCAFE_F00D.
- Fairness: all 4 masters hold req for 8 cycles → grant order 0,1,2,3,0,1,2,3, one grant per cycle, matching r_valid one cycle later.
- Write response: master 1 writes wdata=32'h1234_5678, be=4'b0011 → mem_wen_o=0, mem_be_o=4'b0011; at t+1 r_valid_o[1]=1, r_rdata=0, r_opc=0.
- Reset mid-flight: grant to master 3 in cycle t, rst_i high in t+1 → no r_valid in t+1 or later; after release, master 0 wins first.
- With L2_ARB_ADDR_CHECK_EN defined: master 0 reads 32'h1A00_0000 → gnt_o[0]=1, mem_csn_o=1; at t+1 r_valid_o[0]=1, r_opc_o[0]=1, rdata=32'hBADA_CCE5.
